data_ram_resp: RTL and testbench

DATA_RAM_RESP -- requirements
Module: data_ram_resp

---
 rtl/data_ram_resp.sv | 132 +++++++++++++
 tb/tb_data_ram_resp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_resp.sv
// data_ram_resp: word-addressed data RAM behind a fixed-latency request/ready
// handshake. The data cache strobes one request; the block answers with a
// single-cycle ready pulse LATENCY edges later. Only one request is in flight
// at a time.
module data_ram_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        data_ready_o,
    output logic        busy_o
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    // The counter counts the remaining WAIT edges, so the edge that sees zero
    // is the LATENCY-th edge after the accept.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              cnt;
    logic [3:0]              cnt_next;
    logic                    accept;
    logic                    complete;

    logic                    req_we;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [3:0]              req_sel;
    logic [31:0]             req_data;

    logic [31:0]             mem [DEPTH];

    // High address bits alias and the byte offset is meaningless for word
    // accesses; both are deliberately dropped.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

    // Next-state logic: accept only in IDLE, count down in WAIT, and leave
    // DONE unconditionally so a held ce_i cannot be accepted during DONE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (ce_i) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latency counter register; reset drops any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request at accept so input changes during WAIT/DONE are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we   <= 1'b0;
            req_idx  <= '0;
            req_sel  <= 4'd0;
            req_data <= 32'd0;
        end else if (accept) begin
            req_we   <= we_i;
            req_idx  <= addr_i[DEPTH_LOG2+1:2];
            req_sel  <= sel_i;
            req_data <= data_i;
        end
    end

    // Byte-enabled write on the WAIT->DONE edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (complete && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // Read data register: loads the full word on a read completion, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o <= 32'd0;
        end else if (complete && !req_we) begin
            data_o <= mem[req_idx];
        end
    end

    assign data_ready_o = (state == DONE);
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed testbench for data_ram_resp: a LATENCY=3 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency timing.
module tb_data_ram_resp;

    logic        clk;
    logic        rst;

    logic        ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ready, busy;

    logic        ce1, we1;
    logic [31:0] addr1, wdata1;
    logic [3:0]  sel1;
    logic [31:0] rdata1;
    logic        ready1, busy1;

    int n_tests;
    int n_fail;

    data_ram_resp #(.DEPTH_LOG2(10), .LATENCY(3)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
        .sel_i(sel), .data_i(wdata), .data_o(rdata),
        .data_ready_o(ready), .busy_o(busy)
    );

    data_ram_resp #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we1), .addr_i(addr1),
        .sel_i(sel1), .data_i(wdata1), .data_o(rdata1),
        .data_ready_o(ready1), .busy_o(busy1)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue one request on the LATENCY=3 instance. Called at a negedge with
    // the DUT idle; returns at a negedge with the DUT idle again. lat is the
    // number of edges from accept to the ready pulse (20 on timeout).
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int lat, output logic one_cycle);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFC; sel = 4'hF; wdata = 32'h5555_5555;
        lat = 0;
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        one_cycle = !ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; wdata = 32'd0;
        ce1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; sel1 = 4'd0; wdata1 = 32'd0;
        #1;
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_data got %h expected %h", rdata, 32'd0); end
        n_tests++;
        if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b expected 0", ready); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        n_tests++;
        if ({rdata1, ready1, busy1} !== 34'd0) begin n_fail++; $display("[TB] FAIL reset_dut1 got %h expected 0", {rdata1, ready1, busy1}); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic oc;
        issue(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, lat, oc);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL write_latency got %0d expected 3", lat); end
        n_tests++;
        if (oc !== 1'b1) begin n_fail++; $display("[TB] FAIL write_pulse_width got %b expected 1", oc); end
        n_tests++;
        if (rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL write_keeps_data got %h expected %h", rdata, 32'd0); end
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, oc);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL read_latency got %0d expected 3", lat); end
        n_tests++;
        if (oc !== 1'b1) begin n_fail++; $display("[TB] FAIL read_pulse_width got %b expected 1", oc); end
        n_tests++;
        if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL read_data got %h expected %h", rdata, 32'hDEAD_BEEF); end
    endtask

    task automatic test_byte_write();
        int lat; logic oc;
        issue(1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, lat, oc);
        issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, lat, oc);
        n_tests++;
        if (rdata !== 32'hDEAD_BEAA) begin n_fail++; $display("[TB] FAIL byte_write got %h expected %h", rdata, 32'hDEAD_BEAA); end
        issue(1'b1, 32'h0000_0010, 4'b1100, 32'h1234_5678, lat, oc);
        issue(1'b0, 32'h0000_0010, 4'b0001, 32'h0, lat, oc);
        n_tests++;
        if (rdata !== 32'h1234_BEAA) begin n_fail++; $display("[TB] FAIL upper_bytes got %h expected %h", rdata, 32'h1234_BEAA); end
        issue(1'b1, 32'h0000_0010, 4'b1100, 32'hDEAD_0000, lat, oc);
    endtask

    task automatic test_alias();
        int lat; logic oc;
        issue(1'b0, 32'h0000_1010, 4'h0, 32'h0, lat, oc);
        n_tests++;
        if (rdata !== 32'hDEAD_BEAA) begin n_fail++; $display("[TB] FAIL alias_high got %h expected %h", rdata, 32'hDEAD_BEAA); end
        issue(1'b1, 32'h0000_0014, 4'hF, 32'h0BAD_F00D, lat, oc);
        issue(1'b0, 32'hFFFF_F017, 4'h0, 32'h0, lat, oc);
        n_tests++;
        if (rdata !== 32'h0BAD_F00D) begin n_fail++; $display("[TB] FAIL alias_low_bits got %h expected %h", rdata, 32'h0BAD_F00D); end
    endtask

    task automatic test_sel_zero();
        int lat; logic oc;
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, oc);
        issue(1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, lat, oc);
        n_tests++;
        if (lat !== 3 || oc !== 1'b1) begin n_fail++; $display("[TB] FAIL sel0_ready got lat=%0d one=%b expected lat=3 one=1", lat, oc); end
        issue(1'b1, 32'h0000_0014, 4'hF, 32'h0, lat, oc);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, oc);
        n_tests++;
        if (rdata !== 32'hDEAD_BEAA) begin n_fail++; $display("[TB] FAIL sel0_unchanged got %h expected %h", rdata, 32'hDEAD_BEAA); end
    endtask

    // Read requests held back-to-back while addr_i alternates every cycle.
    task automatic test_back_to_back();
        int lat; logic oc;
        int pulses;
        logic exp_ready;
        logic [31:0] exp_data;
        issue(1'b1, 32'h0000_0030, 4'hF, 32'h0000_3030, lat, oc);
        issue(1'b1, 32'h0000_0034, 4'hF, 32'h0000_3434, lat, oc);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            exp_ready = ((c % 5) == 4);
            n_tests++;
            if (ready !== exp_ready) begin n_fail++; $display("[TB] FAIL b2b_ready cycle %0d got %b expected %b", c, ready, exp_ready); end
            if (exp_ready) begin
                pulses++;
                exp_data = (((c / 5) % 2) == 0) ? 32'h0000_3030 : 32'h0000_3434;
                n_tests++;
                if (rdata !== exp_data) begin n_fail++; $display("[TB] FAIL b2b_data cycle %0d got %h expected %h", c, rdata, exp_data); end
            end
            ce = 1'b1; we = 1'b0; sel = 4'h0; wdata = 32'h0;
            addr = ((c % 2) == 0) ? 32'h0000_0030 : 32'h0000_0034;
            @(negedge clk);
        end
        ce = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_end got %b expected 0", busy); end
        if (pulses != 4) $display("[TB] note: unexpected pulse bookkeeping");
    endtask

    task automatic test_reset_abort();
        int lat; logic oc;
        issue(1'b1, 32'h0000_0020, 4'hF, 32'h0000_0000, lat, oc);
        issue(1'b0, 32'h0000_0010, 4'h0, 32'h0, lat, oc);
        ce = 1'b1; we = 1'b1; addr = 32'h0000_0020; sel = 4'hF; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({rdata, ready, busy} !== 34'd0) begin n_fail++; $display("[TB] FAIL abort_outputs got %h expected 0", {rdata, ready, busy}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_ready step %0d got %b expected 0", k, ready); end
        end
        rst = 1'b0;
        issue(1'b0, 32'h0000_0020, 4'h0, 32'h0, lat, oc);
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("[TB] FAIL first_accept_after_reset got %0d expected 3", lat); end
        n_tests++;
        if (rdata !== 32'h0000_0000) begin n_fail++; $display("[TB] FAIL abort_no_write got %h expected %h", rdata, 32'h0); end
    endtask

    task automatic test_latency1();
        for (int r = 0; r < 2; r++) begin
            ce1 = 1'b1; we1 = (r == 0); addr1 = 32'h0000_0040; sel1 = 4'hF; wdata1 = 32'h1122_3344;
            @(posedge clk);
            @(negedge clk);
            ce1 = 1'b0; wdata1 = 32'h0;
            n_tests++;
            if ({busy1, ready1} !== 2'b10) begin n_fail++; $display("[TB] FAIL lat1_wait got %b expected 10", {busy1, ready1}); end
            @(negedge clk);
            n_tests++;
            if ({busy1, ready1} !== 2'b11) begin n_fail++; $display("[TB] FAIL lat1_done got %b expected 11", {busy1, ready1}); end
            if (r == 1) begin
                n_tests++;
                if (rdata1 !== 32'h1122_3344) begin n_fail++; $display("[TB] FAIL lat1_data got %h expected %h", rdata1, 32'h1122_3344); end
            end
            @(negedge clk);
            n_tests++;
            if ({busy1, ready1} !== 2'b00) begin n_fail++; $display("[TB] FAIL lat1_idle got %b expected 00", {busy1, ready1}); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_alias();
        test_sel_zero();
        test_back_to_back();
        test_latency1();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
